// File: rtl/uart_rx_pkg.sv
// Common types and helpers for the UART receiver.
`include "uart.vh"

package uart_rx_pkg;
  localparam int DATA_W = `UART_DATA_LENGTH;
  localparam int CNT_W  = 3;

  typedef logic [DATA_W-1:0] uart_byte_t;

  // True on the counter value of the last data bit of a frame.
  function automatic logic data_done(input logic [CNT_W-1:0] cnt);
    return cnt == CNT_W'(DATA_W - 1);
  endfunction
endpackage

// File: rtl/uart.vh
// Shared UART definitions used by the transmit and receive blocks.
`ifndef UART_VH
`define UART_VH
`define UART_DATA_LENGTH 8
`endif

// File: rtl/uart_rx_fifo.sv
// Generic first-word-fall-through FIFO; a push into a full FIFO succeeds
// only when a pop happens in the same cycle. DEPTH must be a power of two.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver, one line bit per clock, with a FWFT receive buffer.
// Define UART_RX_FRAME_CHECK_EN to drop bytes with a bad stop bit.
`include "uart.vh"

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  output logic [`UART_DATA_LENGTH-1:0] data_o,
  output logic                         data_o_v,
  input  logic                         data_i_rdy,
  output logic                         frame_err_o,
  output logic                         overrun_o
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  uart_byte_t       shift;
  logic             stop_ok;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             overrun_p1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_i) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift   <= {rx_i, shift[DATA_W-1:1]};
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (data_done(bit_cnt)) state <= ST_STOP;
        end
        ST_STOP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FRAME_CHECK_EN
  logic frame_err_p1;

  assign stop_ok = rx_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) frame_err_p1 <= 1'b0;
    else       frame_err_p1 <= (state == ST_STOP) && !rx_i;
  end

  assign frame_err_o = frame_err_p1;
`else
  assign stop_ok     = 1'b1;
  assign frame_err_o = 1'b0;
`endif

  assign push = (state == ST_STOP) && stop_ok;
  assign pop  = data_o_v && data_i_rdy;

  // Stage p1: overrun flag registered the cycle after the dropped byte.
  always_ff @(posedge clk_i) begin
    if (rst_i) overrun_p1 <= 1'b0;
    else       overrun_p1 <= push && full && !pop;
  end

  assign overrun_o = overrun_p1;
  assign data_o_v  = !empty;

  uart_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (shift),
    .pop   (pop),
    .rdata (data_o),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive buffer depth in bytes; power of two, minimum 2.
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_i  input  1  serial line, idle high, one bit per clk_i cycle.
REQ-005 SHALL have port data_o  output  `UART_DATA_LENGTH  head byte of the receive buffer.
REQ-006 SHALL have port data_o_v  output  1  data_o holds a valid byte.
REQ-007 SHALL have port data_i_rdy  input  1  consumer accepts data_o this cycle.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-010 SHALL use the frame format start bit (0), `UART_DATA_LENGTH data bits LSB first, stop bit (1), each bit one clk_i cycle, 10 cycles per frame.
REQ-011 SHALL implement states ST_IDLE, ST_DATA and ST_STOP.
REQ-012 In ST_IDLE, rx_i==0 SHALL be taken as the start-bit cycle and SHALL move to ST_DATA with the bit counter at 0; rx_i==1 SHALL stay in ST_IDLE.
REQ-013 In ST_DATA, each cycle SHALL shift rx_i into the MSB of the shift register (shift right) and increment a 3-bit counter; at counter==7 the state SHALL move to ST_STOP.
REQ-014 ST_STOP SHALL sample the stop bit on rx_i and always return to ST_IDLE next cycle, so back-to-back frames with zero idle gap are received.
REQ-015 A good frame SHALL write the byte into the buffer at the end of the ST_STOP cycle; if the buffer was empty, data_o_v SHALL rise on the following cycle (first-word-fall-through).
REQ-016 A byte SHALL be popped on a cycle where data_o_v && data_i_rdy; data_o SHALL remain stable while data_o_v && !data_i_rdy.
REQ-017 Full buffer with no pop in the same cycle: the incoming good byte SHALL be dropped and overrun_o SHALL pulse for 1 cycle; contents SHALL be unchanged.
REQ-018 Full buffer with a pop in the same cycle: the push SHALL be accepted and overrun_o SHALL stay 0.
REQ-019 Buffer pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-020 Bytes SHALL be delivered in arrival order.

Reset
REQ-021 While rst_i is high: state SHALL be ST_IDLE, counter 0, shift register 0, buffer empty, data_o_v 0, data_o 0, frame_err_o 0, overrun_o 0.
REQ-022 Reset mid-frame SHALL discard the partial frame; after rst_i falls, the first rx_i==0 cycle SHALL be treated as a start bit.

Configuration
REQ-023 With UART_RX_FRAME_CHECK_EN defined: stop bit 0 SHALL drop the byte and pulse frame_err_o for 1 cycle, the cycle after ST_STOP.
REQ-024 Without UART_RX_FRAME_CHECK_EN: the stop bit SHALL be ignored, every frame SHALL be written, and frame_err_o SHALL be tied to 0.

Structure
REQ-025 UART_DATA_LENGTH (8) SHALL come from the shared uart.vh include.
REQ-026 State encodings SHALL be localparams in uart_rx.
REQ-027 The buffer SHALL be a sub-module uart_rx_fifo (parameters WIDTH, DEPTH; push/pop/full/empty), also usable by other blocks.

Verification
REQ-028 Reset, then frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) with data_i_rdy=1 -> data_o=0xA5 and data_o_v high for exactly 1 cycle, 1 cycle after the stop cycle.
REQ-029 Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap and data_i_rdy=1 -> three single-cycle valids, in order, spaced 10 cycles apart.
REQ-030 data_i_rdy=0 and 5 frames 0x01..0x05 -> overrun_o pulses once on frame 5; releasing ready drains 0x01..0x04, then data_o_v=0.
REQ-031 Frame 0x55 with stop bit 0 -> macro defined: frame_err_o pulses, no valid; macro undefined: data_o=0x55 valid, frame_err_o stays 0.
REQ-032 rst_i asserted during data bit 3 of a frame, then frame 0x81 -> only 0x81 is delivered.
REQ-033 Loopback from the team transmitter (tx_o to rx_i), 256 random bytes -> every byte received in order, no errors.
